tinyalu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one TinyALU between NREQ requesters. It accepts one operation at a time from a requester and drives the ALU start/op/A/B interface, holding start until done. It then returns the 16-bit result to the owning requester. It sits between the requesters and the ALU and rejects illegal opcodes without touching the ALU.

---
 rtl/tinyalu_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_tinyalu_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinyalu_arbiter.sv
// tinyalu_arbiter
// Round-robin arbiter/sequencer that shares one TinyALU between NREQ
// requesters. One operation is accepted at a time and driven onto the ALU,
// with start held until done. The 16-bit result then goes back to the owner.
// Illegal opcodes are answered with an error and never reach the ALU.
//
// Optional feature macro: ALU_ARB_TIMEOUT_EN. When it is defined, an ALU
// operation that is still busy after TIMEOUT_CYCLES start cycles is aborted
// with an error response.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   req_valid/req_ready [NREQ]   per-requester handshake (ready is one-hot)
//   req_A/req_B [NREQ*8]         operands, slice i = [8i+7:8i]
//   req_op [NREQ*3]              opcode, slice i = [3i+2:3i]
//   rsp_valid [NREQ]             one-hot, one-cycle response strobe
//   rsp_result [16], rsp_err     response data / error qualifier
//   busy                         FSM not idle
//   alu_start/op/A/B             ALU command interface
//   alu_done, alu_result         ALU completion pulse and result
//
// state | meaning
// IDLE  | arbitrate; grant winner and latch its operation
// ISSUE | alu_start high, waiting for alu_done (or timeout)
// RESP  | one-cycle response strobe to the owner
module tinyalu_arbiter #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*8-1:0]   req_A,
    input  logic [NREQ*8-1:0]   req_B,
    input  logic [NREQ*3-1:0]   req_op,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [15:0]         rsp_result,
    output logic                rsp_err,
    output logic                busy,
    output logic                alu_start,
    output logic [2:0]          alu_op,
    output logic [7:0]          alu_A,
    output logic [7:0]          alu_B,
    input  logic                alu_done,
    input  logic [15:0]         alu_result
);

    localparam int IW = $clog2(NREQ);
    localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
        $error("tinyalu_arbiter: NREQ must be 2..8 and TIMEOUT_CYCLES 1..255");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state, state_n;
    logic [IW-1:0] last_grant, owner, win;
    logic [IW:0]   scan_idx;
    logic          any_valid;
    logic [7:0]    sel_a, sel_b;
    logic [2:0]    sel_op;
    logic          sel_legal;
    logic [7:0]    lat_a, lat_b;
    logic [2:0]    lat_op;
    logic [15:0]   result_q;
    logic          err_q;
    logic          start_q;
    logic          timeout;

    // Round-robin pick: scan offsets from NREQ down to 1 so that the smallest
    // offset from last_grant (the highest-priority valid requester) wins.
    always_comb begin
        win       = '0;
        scan_idx  = '0;
        any_valid = |req_valid;
        for (int k = NREQ; k >= 1; k--) begin
            scan_idx = {1'b0, last_grant} + (IW+1)'(k);
            if (scan_idx >= NREQ_W) begin
                scan_idx = scan_idx - NREQ_W;
            end
            if (req_valid[scan_idx[IW-1:0]]) begin
                win = scan_idx[IW-1:0];
            end
        end
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IW'(i)) begin
                sel_a  = req_A[i*8 +: 8];
                sel_b  = req_B[i*8 +: 8];
                sel_op = req_op[i*3 +: 3];
            end
        end
        sel_legal = (sel_op != 3'b000) && (sel_op <= 3'b100);
    end

`ifdef ALU_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    // Counter holds the number of ISSUE cycles already completed, so the
    // abort fires in the TIMEOUT_CYCLES-th start cycle.
    assign timeout = (state == ISSUE) && (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state == ISSUE) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            start_q <= 1'b0;
        end else begin
            state   <= state_n;
            start_q <= (state_n == ISSUE);
        end
    end

    always_comb begin
        state_n   = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    req_ready = NREQ'(1) << win;
                    state_n   = sel_legal ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                // done wins over a simultaneous timeout; both leave for RESP
                if (alu_done || timeout) begin
                    state_n = RESP;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= IW'(NREQ - 1);
            owner      <= '0;
            lat_a      <= '0;
            lat_b      <= '0;
            lat_op     <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        lat_a      <= sel_a;
                        lat_b      <= sel_b;
                        lat_op     <= sel_op;
                        owner      <= win;
                        last_grant <= win;
                        result_q   <= '0;
                        err_q      <= ~sel_legal;
                    end
                end
                ISSUE: begin
                    if (alu_done) begin
                        result_q <= alu_result;
                        err_q    <= 1'b0;
                    end else if (timeout) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign alu_start  = start_q;
    assign alu_op     = lat_op;
    assign alu_A      = lat_a;
    assign alu_B      = lat_b;
    assign rsp_valid  = (state == RESP) ? (NREQ'(1) << owner) : '0;
    assign rsp_err    = (state == RESP) & err_q;
    assign rsp_result = result_q;

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Self-checking bench for tinyalu_arbiter: directed scenarios plus a random
// stream of requests, checked against a transaction-level reference model
// (round-robin pick by modular arithmetic, ALU results by plain arithmetic).
module tb_tinyalu_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*8-1:0]   req_A;
    logic [NREQ*8-1:0]   req_B;
    logic [NREQ*3-1:0]   req_op;
    logic [NREQ-1:0]     rsp_valid;
    logic [15:0]         rsp_result;
    logic                rsp_err;
    logic                busy;
    logic                alu_start;
    logic [2:0]          alu_op;
    logic [7:0]          alu_A;
    logic [7:0]          alu_B;
    logic                alu_done;
    logic [15:0]         alu_result;

    always #5 clk = ~clk;

    tinyalu_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_A      (req_A),
        .req_B      (req_B),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_done   (alu_done),
        .alu_result (alu_result)
    );

    int checks = 0;
    int errors = 0;
    int model_last = NREQ - 1;

    logic [7:0] ta [NREQ];
    logic [7:0] tb [NREQ];
    logic [2:0] top[NREQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] vm, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (vm[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return 0;
    endfunction

    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd1:    return 16'(a) + 16'(b);
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a ^ b};
            3'd4:    return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    function automatic bit is_legal(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            req_A[i*8 +: 8]  = ta[i];
            req_B[i*8 +: 8]  = tb[i];
            req_op[i*3 +: 3] = top[i];
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = '0;
        alu_done  = 1'b0;
        @(negedge clk);
        reset      = 1'b0;
        model_last = NREQ - 1;
    endtask

    // One full operation starting from IDLE; req_valid stays at vm throughout.
    task automatic txn(input logic [NREQ-1:0] vm, input int lat, output int w);
        logic [7:0]  ea, eb;
        logic [2:0]  eo;
        logic [15:0] er;
        @(negedge clk);
        req_valid  = vm;
        drive_reqs();
        alu_done   = 1'($urandom_range(0, 1));
        alu_result = 16'($urandom);
        #1;
        w = pick(vm, model_last);
        chk("grant", 32'(req_ready), 32'(1) << w);
        chk("start_at_grant", 32'(alu_start), 0);
        chk("busy_at_grant", 32'(busy), 0);
        chk("rsp_at_grant", 32'(rsp_valid), 0);
        model_last = w;
        ea = ta[w];
        eb = tb[w];
        eo = top[w];
        er = alu_fn(eo, ea, eb);
        if (is_legal(eo)) begin
            for (int cyc = 1; cyc <= lat; cyc++) begin
                @(negedge clk);
                ta[w]  = 8'($urandom);
                tb[w]  = 8'($urandom);
                top[w] = 3'($urandom_range(0, 7));
                drive_reqs();
                alu_done   = (cyc == lat);
                alu_result = (cyc == lat) ? alu_fn(alu_op, alu_A, alu_B) : 16'($urandom);
                #1;
                chk("start_high", 32'(alu_start), 1);
                chk("busy_issue", 32'(busy), 1);
                chk("ready_issue", 32'(req_ready), 0);
                chk("rsp_issue", 32'(rsp_valid), 0);
                chk("alu_op", 32'(alu_op), 32'(eo));
                chk("alu_A", 32'(alu_A), 32'(ea));
                chk("alu_B", 32'(alu_B), 32'(eb));
            end
        end
        @(negedge clk);
        alu_done   = 1'($urandom_range(0, 1));
        alu_result = 16'($urandom);
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(1) << w);
        chk("rsp_result", 32'(rsp_result), is_legal(eo) ? 32'(er) : 0);
        chk("rsp_err", 32'(rsp_err), is_legal(eo) ? 0 : 1);
        chk("start_resp", 32'(alu_start), 0);
        chk("ready_resp", 32'(req_ready), 0);
        alu_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [NREQ-1:0] vm;

        reset      = 1'b1;
        req_valid  = '0;
        alu_done   = 1'b0;
        alu_result = '0;
        for (int i = 0; i < NREQ; i++) begin
            ta[i] = '0; tb[i] = '0; top[i] = 3'd1;
        end
        drive_reqs();

        // reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(alu_start), 0);
        chk("rst_result", 32'(rsp_result), 0);
        chk("rst_alu_op", 32'(alu_op), 0);
        chk("rst_alu_A", 32'(alu_A), 0);
        chk("rst_alu_B", 32'(alu_B), 0);
        reset = 1'b0;

        // add 200+100, done after 3 start cycles
        ta[0] = 8'd200; tb[0] = 8'd100; top[0] = 3'b001;
        txn(4'b0001, 3, w);
        chk("first_owner", 32'(w), 0);

        // all four valid, then 0 and 2 only
        reset_dut();
        for (int i = 0; i < NREQ; i++) begin
            ta[i] = 8'($urandom); tb[i] = 8'($urandom); top[i] = 3'b001;
        end
        for (int n = 0; n < 4; n++) txn(4'b1111, $urandom_range(1, 4), w);
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < NREQ; i++) top[i] = 3'($urandom_range(1, 4));
            txn(4'b0101, $urandom_range(1, 4), w);
        end

        // illegal opcode
        top[1] = 3'b111;
        txn(4'b0010, 1, w);

        // mul 255*255
        ta[2] = 8'd255; tb[2] = 8'd255; top[2] = 3'b100;
        txn(4'b0100, 2, w);

        // reset pulsed during ISSUE drops the operation
        ta[0] = 8'd7; tb[0] = 8'd9; top[0] = 3'b001;
        @(negedge clk);
        req_valid = 4'b0001;
        drive_reqs();
        #1;
        chk("pre_rst_grant", 32'(req_ready), 32'(1) << pick(4'b0001, model_last));
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("pre_rst_start", 32'(alu_start), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        model_last = NREQ - 1;
        #1;
        chk("post_rst_start", 32'(alu_start), 0);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_rsp", 32'(rsp_valid), 0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            alu_done   = 1'b1;
            alu_result = 16'($urandom);
            #1;
            chk("dropped_no_rsp", 32'(rsp_valid), 0);
            chk("dropped_idle", 32'(busy), 0);
        end
        alu_done = 1'b0;
        ta[3] = 8'($urandom); tb[3] = 8'($urandom); top[3] = 3'b011;
        txn(4'b1000, 2, w);

        // random stream
        for (int n = 0; n < 40; n++) begin
            vm = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                ta[i]  = 8'($urandom);
                tb[i]  = 8'($urandom);
                top[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
            end
            txn(vm, $urandom_range(1, 6), w);
        end

        // ALU never answers
        ta[0] = 8'd1; tb[0] = 8'd2; top[0] = 3'b001;
        @(negedge clk);
        req_valid = 4'b0001;
        alu_done  = 1'b0;
        drive_reqs();
        #1;
        w = pick(4'b0001, model_last);
        chk("hang_grant", 32'(req_ready), 32'(1) << w);
        model_last = w;
`ifdef ALU_ARB_TIMEOUT_EN
        for (int cyc = 1; cyc <= TMO; cyc++) begin
            @(negedge clk);
            #1;
            chk("tmo_start", 32'(alu_start), 1);
            chk("tmo_no_rsp", 32'(rsp_valid), 0);
        end
        @(negedge clk);
        #1;
        chk("tmo_rsp_valid", 32'(rsp_valid), 32'(1) << w);
        chk("tmo_rsp_err", 32'(rsp_err), 1);
        chk("tmo_rsp_result", 32'(rsp_result), 0);
        chk("tmo_start_low", 32'(alu_start), 0);
`else
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            #1;
            chk("hang_start", 32'(alu_start), 1);
            chk("hang_busy", 32'(busy), 1);
            chk("hang_no_rsp", 32'(rsp_valid), 0);
        end
`endif
        reset_dut();
        #1;
        chk("final_idle", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
